// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote oversampling, run-time frame format and a
// receive FIFO whose fill level drives rts_n flow control.
module uart_rx_fifo #(
   parameter int FIFO_DEPTH = 16,
   parameter int RTS_THRESH = 12,
   parameter int OVS        = 16,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DIV_W-1:0]              baud_div,
   input  logic [1:0]                    cfg_data_bits,
   input  logic [1:0]                    cfg_parity,
   input  logic                          cfg_stop2,
   input  logic                          rx,
   output logic                          rts_n,
   input  logic                          rd_en,
   output logic                          rd_valid,
   output logic [7:0]                    rd_data,
   output logic [1:0]                    rd_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overrun,
   input  logic                          ovr_clr
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int OW = $clog2(OVS);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

   state_t           r_state, w_nextState;
   logic [1:0]       r_sync;
   logic             w_rxs;
   logic [DIV_W-1:0] r_divCnt;
   logic [OW-1:0]    r_ovsCnt;
   logic             w_tick, w_resolve, w_bitEnd, w_maj;
   logic             r_s0, r_s1;
   logic [3:0]       r_nBits, r_bitCnt;
   logic             r_parEn, r_parOdd, r_stop2;
   logic [7:0]       r_shift, w_data;
   logic             r_parAcc, r_parErr, r_frameErr, w_frameErrNow, r_waitHigh;
   logic             w_push, w_doPush, w_doPop, w_full;
   logic [9:0]       w_pushWord, r_head;
   logic [9:0]       r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wrPtr, r_rdPtr, w_rdNext;
   logic [LW-1:0]    r_level;
   logic             r_ovr, r_rtsN;

   assign w_rxs     = r_sync[1];
   assign w_tick    = (r_state != S_IDLE) && (r_divCnt == '0);
   assign w_resolve = w_tick && (r_ovsCnt == OW'(OVS/2 + 1));
   assign w_bitEnd  = w_tick && (r_ovsCnt == OW'(OVS - 1));
   assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sync <= 2'b11;
      else     r_sync <= {r_sync[0], rx};
   end

   // Tick divider and in-bit tick counter are held at zero in IDLE so every
   // frame's sampling phase is anchored to its own start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_divCnt <= '0;
         r_ovsCnt <= '0;
         r_s0     <= 1'b1;
         r_s1     <= 1'b1;
      end else if (r_state == S_IDLE) begin
         r_divCnt <= '0;
         r_ovsCnt <= '0;
      end else begin
         r_divCnt <= (r_divCnt == '0) ? baud_div : r_divCnt - 1'b1;
         if (w_tick) begin
            r_ovsCnt <= (r_ovsCnt == OW'(OVS - 1)) ? '0 : r_ovsCnt + 1'b1;
            if (r_ovsCnt == OW'(OVS/2 - 1)) r_s0 <= w_rxs;
            if (r_ovsCnt == OW'(OVS/2))     r_s1 <= w_rxs;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      w_push      = 1'b0;
      case (r_state)
         S_IDLE:   if (!w_rxs && !r_waitHigh) w_nextState = S_START;
         S_START:  if (w_resolve && w_maj) w_nextState = S_IDLE;
                   else if (w_bitEnd)      w_nextState = S_DATA;
         S_DATA:   if (w_bitEnd && (r_bitCnt == r_nBits))
                      w_nextState = r_parEn ? S_PARITY : S_STOP1;
         S_PARITY: if (w_bitEnd) w_nextState = S_STOP1;
         S_STOP1:  if (w_resolve && !r_stop2) begin
                      w_push      = 1'b1;
                      w_nextState = S_IDLE;
                   end else if (w_bitEnd) w_nextState = S_STOP2;
         S_STOP2:  if (w_resolve) begin
                      w_push      = 1'b1;
                      w_nextState = S_IDLE;
                   end
         default:  w_nextState = S_IDLE;
      endcase
   end

   assign w_data        = r_shift >> (4'd8 - r_nBits);
   assign w_frameErrNow = r_frameErr | ~w_maj;
   assign w_pushWord    = {r_parErr, w_frameErrNow, w_data};

   // Frame datapath; a low stop bit leaves the line low, so the receiver waits
   // for an idle level before it can arm on another start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_nBits    <= 4'd8;
         r_parEn    <= 1'b0;
         r_parOdd   <= 1'b0;
         r_stop2    <= 1'b0;
         r_bitCnt   <= '0;
         r_shift    <= '0;
         r_parAcc   <= 1'b0;
         r_parErr   <= 1'b0;
         r_frameErr <= 1'b0;
         r_waitHigh <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_nextState == S_START) begin
            r_nBits    <= {2'b00, cfg_data_bits} + 4'd5;
            r_parEn    <= (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
            r_parOdd   <= (cfg_parity == 2'd2);
            r_stop2    <= cfg_stop2;
            r_bitCnt   <= '0;
            r_parAcc   <= 1'b0;
            r_parErr   <= 1'b0;
            r_frameErr <= 1'b0;
         end
         if (r_state == S_DATA && w_resolve) begin
            r_shift  <= {w_maj, r_shift[7:1]};
            r_parAcc <= r_parAcc ^ w_maj;
            r_bitCnt <= r_bitCnt + 1'b1;
         end
         if (r_state == S_PARITY && w_resolve) r_parErr <= w_maj ^ r_parAcc ^ r_parOdd;
         if ((r_state == S_STOP1 || r_state == S_STOP2) && w_resolve && !w_maj) r_frameErr <= 1'b1;
         if (w_push && w_frameErrNow) r_waitHigh <= 1'b1;
         else if (w_rxs)              r_waitHigh <= 1'b0;
      end
   end

   assign w_full   = (r_level == LW'(FIFO_DEPTH));
   assign w_doPop  = rd_en && (r_level != '0);
   assign w_doPush = w_push && (!w_full || w_doPop);
   assign w_rdNext = r_rdPtr + 1'b1;

   always_ff @(posedge clk) begin
      if (w_doPush) r_mem[r_wrPtr] <= w_pushWord;
   end

   // The head is a register so it can hold the last character when empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
         r_head  <= '0;
         r_ovr   <= 1'b0;
         r_rtsN  <= 1'b0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)  r_rdPtr <= w_rdNext;
         case ({w_doPush, w_doPop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         if (w_doPush && ((r_level == '0) || ((r_level == LW'(1)) && w_doPop)))
            r_head <= w_pushWord;
         else if (w_doPop && (r_level > LW'(1)))
            r_head <= r_mem[w_rdNext];
         if (w_push && !w_doPush) r_ovr <= 1'b1;
         else if (ovr_clr)        r_ovr <= 1'b0;
         r_rtsN <= (r_level >= LW'(RTS_THRESH));
      end
   end

   assign rts_n      = r_rtsN;
   assign rd_valid   = (r_level != '0);
   assign rd_data    = r_head[7:0];
   assign rd_err     = r_head[9:8];
   assign fifo_level = r_level;
   assign overrun    = r_ovr;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frames are built bit by bit from a
// frame description and compared against a queue model of the receive FIFO.
module tb_uart_rx_fifo;
   localparam int DEPTH  = 16;
   localparam int THRESH = 12;
   localparam int OVS    = 16;
   localparam int DIVW   = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [DIVW-1:0] baud_div;
   logic [1:0]      cfg_data_bits;
   logic [1:0]      cfg_parity;
   logic            cfg_stop2;
   logic            rx;
   logic            rts_n;
   logic            rd_en;
   logic            rd_valid;
   logic [7:0]      rd_data;
   logic [1:0]      rd_err;
   logic [4:0]      fifo_level;
   logic            overrun;
   logic            ovr_clr;

   int         nTests = 0;
   int         nFail  = 0;
   int         bitClk;
   logic [9:0] modelQ[$];
   logic       modelOvr;
   logic [9:0] lastWord;

   uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .RTS_THRESH(THRESH), .OVS(OVS), .DIV_W(DIVW)) dut (
      .clk(clk), .rst(rst), .baud_div(baud_div), .cfg_data_bits(cfg_data_bits),
      .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .rx(rx), .rts_n(rts_n),
      .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
      .fifo_level(fifo_level), .overrun(overrun), .ovr_clr(ovr_clr)
   );

   always #5 clk = ~clk;

   // Hard stop in case the design wedges the sequence somewhere unexpected.
   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic driveBit(input logic v, input int clocks);
      rx = v;
      repeat (clocks) @(negedge clk);
   endtask

   // Model a frame at character level: data masked to N bits, parity error
   // exactly when the sent parity bit was flipped, frame error on a low stop.
   task automatic modelPush(input logic [7:0] d, input int nb, input logic parEn,
                            input logic flipPar, input logic badStop);
      logic [7:0] mask;
      mask = 8'hFF >> (8 - nb);
      if (modelQ.size() == DEPTH) modelOvr = 1'b1;
      else modelQ.push_back({parEn & flipPar, badStop, d & mask});
   endtask

   task automatic applyStimulus(input logic [7:0] d, input int nb, input logic [1:0] par,
                                input logic st2, input logic flipPar, input logic badStop);
      logic       parEn;
      logic       pBit;
      logic [7:0] mask;
      mask          = 8'hFF >> (8 - nb);
      parEn         = (par == 2'd1) || (par == 2'd2);
      pBit          = (^(d & mask)) ^ (par == 2'd2) ^ flipPar;
      cfg_data_bits = 2'(nb - 5);
      cfg_parity    = par;
      cfg_stop2     = st2;
      driveBit(1'b0, bitClk);
      cfg_data_bits = 2'($urandom);
      cfg_parity    = 2'($urandom);
      cfg_stop2     = 1'($urandom);
      for (int i = 0; i < nb; i++) driveBit(d[i], bitClk);
      if (parEn) driveBit(pBit, bitClk);
      for (int s = 0; s < (st2 ? 2 : 1); s++) driveBit(!badStop, bitClk);
      driveBit(1'b1, bitClk);
      modelPush(d, nb, parEn, flipPar, badStop);
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, "_level"}, 32'(fifo_level), modelQ.size());
      checkOutput({tag, "_valid"}, 32'(rd_valid), 32'(modelQ.size() != 0));
      checkOutput({tag, "_rts"}, 32'(rts_n), 32'(modelQ.size() >= THRESH));
      checkOutput({tag, "_ovr"}, 32'(overrun), 32'(modelOvr));
      if (modelQ.size() != 0) checkOutput({tag, "_head"}, {rd_err, rd_data}, modelQ[0]);
   endtask

   task automatic popAndCheck(input string tag);
      checkOutput({tag, "_head"}, {rd_err, rd_data}, modelQ[0]);
      lastWord = modelQ.pop_front();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      checkOutput({tag, "_lvl"}, 32'(fifo_level), modelQ.size());
   endtask

   initial begin
      rst = 1'b1; rx = 1'b1; rd_en = 1'b0; ovr_clr = 1'b0;
      baud_div = 16'd26; cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
      modelOvr = 1'b0;
      bitClk = (27) * OVS;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_rts", 32'(rts_n), 0);
      checkOutput("reset_valid", 32'(rd_valid), 0);
      checkOutput("reset_word", {rd_err, rd_data}, 0);
      checkOutput("reset_level", 32'(fifo_level), 0);
      checkOutput("reset_ovr", 32'(overrun), 0);

      // 8N1 0x55 at baud_div 26, with the push landing mid stop bit.
      driveBit(1'b0, bitClk);
      for (int i = 0; i < 8; i++) driveBit(1'((8'h55 >> i) & 1), bitClk);
      rx = 1'b1;
      repeat (8 * 27) @(negedge clk);
      checkOutput("t1_before_push", 32'(fifo_level), 0);
      repeat (3 * 27) @(negedge clk);
      checkOutput("t1_after_push", 32'(fifo_level), 1);
      repeat (bitClk - 11 * 27 + bitClk) @(negedge clk);
      modelPush(8'h55, 8, 1'b0, 1'b0, 1'b0);
      checkOutput("t1_data", {rd_err, rd_data}, 10'h055);
      checkState("t1");
      popAndCheck("t1_pop");

      baud_div = 16'd3;
      bitClk   = 4 * OVS;

      // 7E2: good parity, then flipped parity.
      applyStimulus(8'h41, 7, 2'd1, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h41, 7, 2'd1, 1'b1, 1'b1, 1'b0);
      checkState("t2");
      checkOutput("t2_first", {rd_err, rd_data}, 10'h041);
      popAndCheck("t2_pop0");
      checkOutput("t2_second", {rd_err, rd_data}, 10'h241);
      popAndCheck("t2_pop1");

      // 5O1 with a low stop bit, then a clean frame.
      applyStimulus(8'h1F, 5, 2'd2, 1'b0, 1'b0, 1'b1);
      checkOutput("t3_frame_err", {rd_err, rd_data}, 10'h11F);
      popAndCheck("t3_pop0");
      applyStimulus(8'h0A, 5, 2'd2, 1'b0, 1'b0, 1'b0);
      checkState("t3_next");
      popAndCheck("t3_pop1");

      // Glitch shorter than half a bit must not start a frame.
      driveBit(1'b0, (OVS / 4) * 4);
      driveBit(1'b1, 2 * bitClk);
      checkState("t4_glitch");
      applyStimulus(8'($urandom), 8, 2'd0, 1'b0, 1'b0, 1'b0);
      checkState("t4_after");
      popAndCheck("t4_pop");

      // Randomised formats, mid-frame configuration churn and error injection.
      for (int k = 0; k < 8; k++) begin
         applyStimulus(8'($urandom), int'($urandom_range(5, 8)), 2'($urandom), 1'($urandom),
                       1'($urandom), ($urandom_range(0, 3) == 0));
         checkState("rnd");
         popAndCheck("rnd_pop");
      end

      // Fill past capacity with no reads, then drain in order.
      for (int k = 0; k < DEPTH + 1; k++) begin
         applyStimulus(8'($urandom), 8, 2'd0, 1'b0, 1'b0, 1'b0);
         checkState("fill");
      end
      for (int k = 0; k < DEPTH; k++) popAndCheck("drain");
      @(negedge clk);
      checkOutput("drain_hold", {rd_err, rd_data}, lastWord);
      checkState("drained");
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      @(negedge clk);
      checkOutput("empty_pop_level", 32'(fifo_level), 0);
      checkOutput("empty_pop_hold", {rd_err, rd_data}, lastWord);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr  = 1'b0;
      modelOvr = 1'b0;
      checkState("ovr_clr");

      // Asynchronous reset in the middle of a data bit with entries queued.
      for (int k = 0; k < 3; k++) applyStimulus(8'($urandom), 8, 2'd0, 1'b0, 1'b0, 1'b0);
      checkState("pre_rst");
      driveBit(1'b0, bitClk);
      driveBit(1'b1, bitClk);
      driveBit(1'b0, bitClk / 2);
      rst = 1'b1;
      #1;
      checkOutput("rst_level", 32'(fifo_level), 0);
      checkOutput("rst_valid", 32'(rd_valid), 0);
      checkOutput("rst_rts", 32'(rts_n), 0);
      checkOutput("rst_word", {rd_err, rd_data}, 0);
      rx = 1'b1;
      modelQ.delete();
      modelOvr = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12 * bitClk) @(negedge clk);
      checkState("post_rst_idle");
      applyStimulus(8'hA7, 8, 2'd0, 1'b0, 1'b0, 1'b0);
      checkState("post_rst_frame");
      popAndCheck("post_rst_pop");

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receive channel with a built-in receive FIFO. It oversamples the serial `rx` line and runs a frame state machine with majority-vote centre sampling. Data width, parity and stop bits are selected at run time. Received characters and their per-character error flags are buffered, and `rts_n` flow control is driven from the FIFO fill level. It sits between the pad-side `rx`/`rts_n` pins and the APB register block, which reads the FIFO.

## Interface
Parameters:
- `FIFO_DEPTH`, 16, number of FIFO entries; power of two, ≥4.
- `RTS_THRESH`, 12, fill level at which `rts_n` deasserts; range 1..FIFO_DEPTH.
- `OVS`, 16, oversample ticks per bit; even, ≥8.
- `DIV_W`, 16, width of `baud_div`.

Ports:
- `clk` in 1: single clock. All logic is in this domain.
- `rst` in 1: asynchronous, active-high reset.
- `baud_div` in DIV_W: one oversample tick every `baud_div`+1 clocks. Example: 50 MHz at 115200 baud with OVS=16 uses 26.
- `cfg_data_bits` in 2: 0→5, 1→6, 2→7, 3→8 data bits.
- `cfg_parity` in 2: 0 none, 1 even, 2 odd, 3 treated as none.
- `cfg_stop2` in 1: 1 selects two stop bits.
- `rx` in 1: asynchronous serial input; idle level is 1.
- `rts_n` out 1: 0 means ready to receive.
- `rd_en` in 1: pops the FIFO head.
- `rd_valid` out 1: FIFO not empty.
- `rd_data` out 8: head character; unused MSBs are 0.
- `rd_err` out 2: head flags, {parity_err, frame_err}.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current number of entries.
- `overrun` out 1: sticky flag; set when a character is dropped because the FIFO is full.
- `ovr_clr` in 1: clears `overrun`.

## Operation
**Input synchroniser**
- `rx` passes through a 2-flop synchroniser; both flops reset to 1.
- All FSM decisions use the synchronised value `rxs`.

**Tick generator**
- Free-running down-counter, reloaded with `baud_div`.
- Produces a 1-clock `tick` pulse.
- Resets to 0 whenever the FSM leaves IDLE, so that each frame is phase-aligned to its start edge.

**Bit sampling**
- Within each bit, a tick counter runs 0..OVS-1.
- The bit value is the majority of `rxs` at ticks OVS/2-1, OVS/2 and OVS/2+1.
- The bit is resolved at tick OVS/2+1.

**Frame FSM**
- IDLE:
  - On `rxs`=0, latch `cfg_*` and go to START.
  - Configuration changes mid-frame have no effect on the current frame.
- START:
  - Resolved bit 1: false start; return to IDLE and push nothing.
  - Resolved bit 0: go to DATA at the end of the bit.
- DATA:
  - Receive N bits, LSB first, into a shift register.
  - Then go to PARITY if parity is enabled, otherwise to STOP.
- PARITY:
  - Received bit is compared with the even/odd parity of the N data bits.
  - A mismatch sets parity_err.
- STOP1:
  - Resolved bit 0 sets frame_err.
  - If `cfg_stop2`=1, go to STOP2 at the end of the bit.
  - Otherwise, at the resolve tick: push the character and go to IDLE (half-bit early, for resynchronisation).
- STOP2:
  - Resolved bit 0 sets frame_err.
  - Push at the resolve tick, then go to IDLE.
- Break condition (all bits 0): push `rd_data`=0 with frame_err=1. The FSM then waits in IDLE for `rxs`=1 before arming a new start.

**FIFO**
- Circular buffer; each entry is 10 bits (data + flags).
- Push when full: the character is dropped, `overrun` is set, and pointers and level are unchanged.
- `rd_en` while empty is ignored.
- Push and pop in the same cycle: both happen and the level is unchanged. This also applies when full, where the push succeeds because of the simultaneous pop.
- If `ovr_clr` and a set condition occur together, set wins.

**Flow control**
- `rts_n` is registered: 1 when `fifo_level` ≥ RTS_THRESH, 0 otherwise.
- Deassertion does not abort a frame in progress.

## Timing
- Reset values:
  - FSM in IDLE.
  - `rts_n`=0, `rd_valid`=0, `rd_data`=0, `rd_err`=0, `fifo_level`=0, `overrun`=0.
  - Synchroniser flops at 1.
- Start detect latency: 2 clocks of synchroniser after the `rx` falling edge, plus 1 clock to enter START.
- Push timing: at the resolve tick of the last stop bit. That is (1+N+P+S-1)·OVS + OVS/2+1 ticks after START entry, where P is 1 if parity is enabled and S is 1 or 2.
- Push to flags:
  - `rd_valid`, `fifo_level` and `rd_data` update on the clock after the push cycle.
  - `rts_n` updates 1 clock after `fifo_level`.
- Pop: `rd_en` with `rd_valid`=1 presents the next head, and decrements `fifo_level`, on the following clock. `rd_data` holds its value when the FIFO is empty.
- Reset mid-frame or mid-FIFO: everything returns to reset values immediately (asynchronous). No partial character is pushed after reset releases.

## Test plan
- 8N1, 0x55, `baud_div`=26 → one entry with `rd_data`=0x55, `rd_err`=00; push about 9.5 bit times after the start edge; `rts_n` stays 0.
- 7E2, 0x41 sent with correct parity, then 0x41 sent with flipped parity → two entries: `rd_data`=0x41 with `rd_err`=00, then 0x41 with `rd_err`=10.
- 5O1, 0x1F with stop bit forced to 0 → `rd_data`=0x1F, `rd_err`=01; a following valid frame decodes correctly.
- Glitch: `rx` low for OVS/4 ticks, then high → no push, FSM back in IDLE.
- With `rd_en`=0, send RTS_THRESH characters → `rts_n`=1. Send the rest up to FIFO_DEPTH+1 total → level=16, `overrun`=1, and the 17th character is absent. Then pop 16 → data in order; `ovr_clr` → `overrun`=0.
- Assert `rst` mid-DATA with 3 entries queued → all outputs at reset values; the next clean frame yields a single correct entry.
